orion_mem_arbiter: RTL and testbench
====================================

Name: orion_mem_arbiter

Overview:
- Shares the single-port 2 MB system RAM between the CPU bus adapter and the video scan-out fetcher.
- Sits between the page/window address decode (which produces the 21-bit physical address) and the RAM array.
- Issues at most one memory access per clock and pipelines read returns with owner tags.
- Uses fair alternation when both requesters are pending, and a fixed-length burst for video.

Parameters:
ADDR_W, 21, physical RAM address width
DATA_W, 8, data width
RD_LAT, 2, cycles from issue (o_mem_ce high) to i_mem_rdata valid; legal range 1..4
VID_BURST, 4, reads per video burst; legal range 1..16

Ports:
i_clk  in  1  system clock; all logic on posedge
i_reset  in  1  synchronous reset, active-high
i_cpu_req  in  1  CPU access request; level, held until o_cpu_ack
i_cpu_we  in  1  1 = write, 0 = read; stable while i_cpu_req
i_cpu_addr  in  ADDR_W  CPU physical address
i_cpu_wdata  in  DATA_W  CPU write data
o_cpu_ack  out  1  one-cycle completion pulse
o_cpu_rdata  out  DATA_W  read data; valid when o_cpu_ack is high and the access was a read
i_vid_req  in  1  video burst request; level, held until o_vid_ack
i_vid_addr  in  ADDR_W  burst start address
o_vid_ack  out  1  one-cycle pulse; burst accepted
o_vid_rvalid  out  1  one pulse per returned burst word
o_vid_rdata  out  DATA_W  burst word; valid with o_vid_rvalid
o_mem_ce  out  1  memory access strobe
o_mem_we  out  1  write enable; qualified by o_mem_ce
o_mem_addr  out  ADDR_W  memory address
o_mem_wdata  out  DATA_W  memory write data
i_mem_rdata  in  DATA_W  memory read data
o_busy  out  1  burst in progress, or any read in flight

Behaviour:
- Reset:
  - All outputs reset to 0.
  - FSM goes to IDLE, the tag pipe is cleared, the fairness flag is cleared (video wins first), and the CPU-outstanding flag is cleared.
  - Reset mid-burst or mid-read aborts the operation. In-flight data is discarded and no ack or rvalid pulse is produced after reset.
- All o_mem_* outputs and ack/rvalid/rdata are registered.
- Issue cycle T is the cycle o_mem_ce is high. i_mem_rdata is sampled at the end of T+RD_LAT.
- Tag pipe: a shift register RD_LAT deep carrying {valid, owner}.
  - Each read issue pushes {1, owner}; the entry emerges at T+RD_LAT.
  - Owner CPU: o_cpu_rdata <= i_mem_rdata and o_cpu_ack = 1 in cycle T+RD_LAT+1.
  - Owner VID: o_vid_rdata <= i_mem_rdata and o_vid_rvalid = 1 in cycle T+RD_LAT+1.
- CPU write: o_cpu_ack in T+1; o_cpu_rdata is unchanged.
- CPU-outstanding flag:
  - Set on CPU issue, cleared when o_cpu_ack is emitted.
  - While set, or in the cycle o_cpu_ack is high, i_cpu_req is ignored. The requester drops the request on the ack.
- FSM states:
  - IDLE:
    - Eligible requesters: CPU (req and not outstanding) and VID (req).
    - If only one is eligible, it is granted.
    - If both are eligible, grant CPU when the fairness flag = 1 (last grant was VID), otherwise grant VID.
    - CPU grant: issue this cycle with o_mem_addr = i_cpu_addr and o_mem_we = i_cpu_we. Clear the fairness flag. Stay in IDLE.
    - VID grant: latch i_vid_addr, issue word 0 and pulse o_vid_ack in this cycle, set the fairness flag. Go to VID if VID_BURST > 1, otherwise stay in IDLE.
  - VID:
    - Issue words 1..VID_BURST-1 on consecutive cycles, always reads.
    - Address = start + k, wrapping modulo 2^ADDR_W (0x1FFFFF + 1 = 0x000000).
    - CPU is not granted during VID. Return to IDLE after the last word is issued.
- A new video request held across a burst end is re-arbitrated in IDLE, so a pending CPU request wins first (no starvation).
- Fairness flag rule: a grant that is the only eligible requester still updates the flag.
- CPU and VID reads interleave freely in the tag pipe. Return order equals issue order.
- o_mem_ce = 0 in cycles with no grant. o_mem_addr and o_mem_wdata hold their last value.

Test Plan:
- CPU write 0x5A to 0x012345, then read the same address (RD_LAT=2): write ack at T+1; read issued at T', o_cpu_ack at T'+3 with o_cpu_rdata = 0x5A; exactly one o_mem_ce per access.
- Video burst at 0x1FFFFE with VID_BURST=4: o_mem_addr sequence 0x1FFFFE, 0x1FFFFF, 0x000000, 0x000001 on 4 consecutive cycles; o_vid_ack on the first; 4 o_vid_rvalid pulses on consecutive cycles, starting 3 cycles after the first issue.
- CPU and video requests raised in the same cycle straight out of reset: video burst granted first; CPU issued the cycle after the burst ends; CPU rdata is correct and interleaves with video returns in issue order.
- Video request held continuously plus a CPU read repeated on each ack: grants alternate burst, CPU, burst, CPU; no requester waits more than VID_BURST+1 cycles for issue.
- Reset asserted in the 2nd cycle of a burst with reads in flight: all outputs 0 the next cycle; no o_vid_rvalid or o_cpu_ack after reset; a new CPU read after reset completes normally.

Source files
------------

// File: rtl/orion_mem_arbiter.sv
// Single-port system RAM arbiter between the CPU bus adapter and video fetcher.
// Registered memory strobe, fair CPU/video alternation, tagged read returns.
module orion_mem_arbiter #(
    parameter int ADDR_W    = 21,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 2,
    parameter int VID_BURST = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_ack,
    output logic [DATA_W-1:0] o_cpu_rdata,
    input  logic              i_vid_req,
    input  logic [ADDR_W-1:0] i_vid_addr,
    output logic              o_vid_ack,
    output logic              o_vid_rvalid,
    output logic [DATA_W-1:0] o_vid_rdata,
    output logic              o_mem_ce,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_busy
);

    localparam int CNT_W = $clog2(VID_BURST + 1);

    typedef enum logic {
        S_IDLE,
        S_VID
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                fair_q, fair_d;
    logic                out_q, out_d;
    logic                ce_q, ce_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                owner_q, owner_d;
    logic                vid_ack_q, vid_ack_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic                vid_rvalid_q, vid_rvalid_d;
    logic [DATA_W-1:0]   vid_rdata_q, vid_rdata_d;
    logic [RD_LAT-1:0]   tag_v_q, tag_v_d;
    logic [RD_LAT-1:0]   tag_o_q, tag_o_d;
    logic                cpu_elig;
    logic                vid_elig;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        cnt_d        = cnt_q;
        fair_d       = fair_q;
        out_d        = out_q;
        ce_d         = 1'b0;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        owner_d      = owner_q;
        vid_ack_d    = 1'b0;
        cpu_ack_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        vid_rvalid_d = 1'b0;
        vid_rdata_d  = vid_rdata_q;

        // Slot 0 of the tag pipe describes the access on the bus right now.
        tag_v_d[0] = ce_q & ~we_q;
        tag_o_d[0] = owner_q;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_v_d[i] = tag_v_q[i-1];
            tag_o_d[i] = tag_o_q[i-1];
        end

        if (tag_v_q[RD_LAT-1]) begin
            if (tag_o_q[RD_LAT-1]) begin
                vid_rvalid_d = 1'b1;
                vid_rdata_d  = i_mem_rdata;
            end else begin
                cpu_ack_d   = 1'b1;
                cpu_rdata_d = i_mem_rdata;
            end
        end
        if (ce_q && we_q) begin
            cpu_ack_d = 1'b1;
        end
        if (cpu_ack_d) begin
            out_d = 1'b0;
        end

        cpu_elig = i_cpu_req & ~out_q & ~cpu_ack_q;
        vid_elig = i_vid_req & ~vid_ack_q;

        unique case (state_q)
            S_IDLE: begin
                if (cpu_elig && (!vid_elig || fair_q)) begin
                    ce_d    = 1'b1;
                    we_d    = i_cpu_we;
                    addr_d  = i_cpu_addr;
                    wdata_d = i_cpu_wdata;
                    owner_d = 1'b0;
                    fair_d  = 1'b0;
                    out_d   = 1'b1;
                end else if (vid_elig) begin
                    ce_d      = 1'b1;
                    addr_d    = i_vid_addr;
                    base_d    = i_vid_addr;
                    cnt_d     = CNT_W'(1);
                    owner_d   = 1'b1;
                    vid_ack_d = 1'b1;
                    fair_d    = 1'b1;
                    if (VID_BURST > 1) begin
                        state_d = S_VID;
                    end
                end
            end
            S_VID: begin
                ce_d    = 1'b1;
                addr_d  = base_q + ADDR_W'(cnt_q);
                owner_d = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(VID_BURST - 1)) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            cnt_q        <= '0;
            fair_q       <= 1'b0;
            out_q        <= 1'b0;
            ce_q         <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            owner_q      <= 1'b0;
            vid_ack_q    <= 1'b0;
            cpu_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            vid_rvalid_q <= 1'b0;
            vid_rdata_q  <= '0;
            tag_v_q      <= '0;
            tag_o_q      <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            cnt_q        <= cnt_d;
            fair_q       <= fair_d;
            out_q        <= out_d;
            ce_q         <= ce_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            owner_q      <= owner_d;
            vid_ack_q    <= vid_ack_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            vid_rvalid_q <= vid_rvalid_d;
            vid_rdata_q  <= vid_rdata_d;
            tag_v_q      <= tag_v_d;
            tag_o_q      <= tag_o_d;
        end
    end

    assign o_cpu_ack    = cpu_ack_q;
    assign o_cpu_rdata  = cpu_rdata_q;
    assign o_vid_ack    = vid_ack_q;
    assign o_vid_rvalid = vid_rvalid_q;
    assign o_vid_rdata  = vid_rdata_q;
    assign o_mem_ce     = ce_q;
    assign o_mem_we     = we_q;
    assign o_mem_addr   = addr_q;
    assign o_mem_wdata  = wdata_q;
    assign o_busy       = (state_q == S_VID) | (|tag_v_q) | (ce_q & ~we_q);

endmodule

// File: tb/tb_orion_mem_arbiter.sv
// Directed bench for orion_mem_arbiter with a 2-cycle-latency RAM model.
// Expected cycles and data are hand-derived for the default parameters.
module tb_orion_mem_arbiter;

    localparam int ADDR_W    = 21;
    localparam int DATA_W    = 8;
    localparam int RD_LAT    = 2;
    localparam int VID_BURST = 4;

    logic              clk = 1'b0;
    logic              i_reset;
    logic              i_cpu_req;
    logic              i_cpu_we;
    logic [ADDR_W-1:0] i_cpu_addr;
    logic [DATA_W-1:0] i_cpu_wdata;
    logic              o_cpu_ack;
    logic [DATA_W-1:0] o_cpu_rdata;
    logic              i_vid_req;
    logic [ADDR_W-1:0] i_vid_addr;
    logic              o_vid_ack;
    logic              o_vid_rvalid;
    logic [DATA_W-1:0] o_vid_rdata;
    logic              o_mem_ce;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              o_busy;

    int vec = 0;
    int err = 0;

    always #5 clk = ~clk;

    orion_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .RD_LAT(RD_LAT), .VID_BURST(VID_BURST)
    ) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we),
        .i_cpu_addr(i_cpu_addr), .i_cpu_wdata(i_cpu_wdata),
        .o_cpu_ack(o_cpu_ack), .o_cpu_rdata(o_cpu_rdata),
        .i_vid_req(i_vid_req), .i_vid_addr(i_vid_addr),
        .o_vid_ack(o_vid_ack), .o_vid_rvalid(o_vid_rvalid),
        .o_vid_rdata(o_vid_rdata),
        .o_mem_ce(o_mem_ce), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata), .o_busy(o_busy)
    );

    // RAM model: unwritten bytes read as (addr[7:0] ^ 8'hA5).
    logic [7:0]   mem [0:255];
    logic [255:0] written = '0;
    logic [7:0]   rp0 = 8'hEE;
    logic [7:0]   rp1 = 8'hEE;

    always @(posedge clk) begin
        if (o_mem_ce && o_mem_we) begin
            mem[o_mem_addr[7:0]]     <= o_mem_wdata;
            written[o_mem_addr[7:0]] <= 1'b1;
        end
        if (o_mem_ce && !o_mem_we) begin
            rp0 <= written[o_mem_addr[7:0]] ? mem[o_mem_addr[7:0]]
                                            : (o_mem_addr[7:0] ^ 8'hA5);
        end else begin
            rp0 <= 8'hEE;
        end
        rp1 <= rp0;
    end
    assign i_mem_rdata = rp1;

    task automatic do_reset();
        i_reset     = 1'b1;
        i_cpu_req   = 1'b0;
        i_cpu_we    = 1'b0;
        i_cpu_addr  = '0;
        i_cpu_wdata = '0;
        i_vid_req   = 1'b0;
        i_vid_addr  = '0;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [69:0] outs;
        do_reset();
        outs = {o_cpu_ack, o_cpu_rdata, o_vid_ack, o_vid_rvalid, o_vid_rdata,
                o_mem_ce, o_mem_we, o_mem_addr, o_mem_wdata, o_busy};
        vec++;
        if (outs !== '0) begin
            err++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
    endtask

    task automatic test_write_read();
        int          n_ce, k_ce, n_ack, k_ack;
        logic        we_s;
        logic [20:0] ad_s;
        logic [7:0]  wd_s, rd_s;
        for (int a = 0; a < 2; a++) begin
            i_cpu_req   = 1'b1;
            i_cpu_we    = (a == 0);
            i_cpu_addr  = 21'h012345;
            i_cpu_wdata = 8'h5A;
            n_ce = 0; k_ce = -1; n_ack = 0; k_ack = -1;
            we_s = 1'bx; ad_s = 'x; wd_s = 'x; rd_s = 'x;
            for (int k = 1; k <= 7; k++) begin
                @(negedge clk);
                if (o_mem_ce) begin
                    n_ce++; k_ce = k;
                    we_s = o_mem_we; ad_s = o_mem_addr; wd_s = o_mem_wdata;
                end
                if (o_cpu_ack) begin
                    n_ack++;
                    if (k_ack < 0) k_ack = k;
                    rd_s = o_cpu_rdata;
                    i_cpu_req = 1'b0;
                end
            end
            vec++;
            if (n_ce != 1 || k_ce != 1) begin
                err++;
                $display("FAIL cpu%0d_issue: got %0d strobes at cycle %0d want 1 at 1",
                         a, n_ce, k_ce);
            end
            vec++;
            if (ad_s !== 21'h012345 || we_s !== (a == 0)) begin
                err++;
                $display("FAIL cpu%0d_bus: got addr %h we %b want 012345 we %b",
                         a, ad_s, we_s, (a == 0));
            end
            vec++;
            if (n_ack != 1 || k_ack != ((a == 0) ? 2 : 4)) begin
                err++;
                $display("FAIL cpu%0d_ack: got %0d acks first at %0d want 1 at %0d",
                         a, n_ack, k_ack, (a == 0) ? 2 : 4);
            end
            vec++;
            if (a == 0) begin
                if (wd_s !== 8'h5A || rd_s !== 8'h00) begin
                    err++;
                    $display("FAIL cpu_write_data: got wdata %h rdata %h want 5a 00",
                             wd_s, rd_s);
                end
            end else begin
                if (rd_s !== 8'h5A) begin
                    err++;
                    $display("FAIL cpu_read_data: got %h want 5a", rd_s);
                end
            end
        end
    endtask

    task automatic test_vid_burst_wrap();
        logic [20:0] exp_a [4];
        logic [7:0]  exp_d [4];
        int n_ce, n_rv, n_ack;
        exp_a = '{21'h1FFFFE, 21'h1FFFFF, 21'h000000, 21'h000001};
        exp_d = '{8'h5B, 8'h5A, 8'hA5, 8'hA4};
        n_ce = 0; n_rv = 0; n_ack = 0;
        i_vid_req  = 1'b1;
        i_vid_addr = 21'h1FFFFE;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (o_mem_ce) begin
                vec++;
                if (n_ce >= 4) begin
                    err++;
                    $display("FAIL vid_extra_issue: got strobe at cycle %0d want none", k);
                end else if (k != n_ce + 1 || o_mem_addr !== exp_a[n_ce] || o_mem_we !== 1'b0) begin
                    err++;
                    $display("FAIL vid_issue%0d: got addr %h we %b cycle %0d want %h 0 cycle %0d",
                             n_ce, o_mem_addr, o_mem_we, k, exp_a[n_ce], n_ce + 1);
                end
                n_ce++;
            end
            if (o_vid_ack) begin
                n_ack++;
                vec++;
                if (k != 1) begin
                    err++;
                    $display("FAIL vid_ack_cycle: got %0d want 1", k);
                end
                i_vid_req = 1'b0;
            end
            if (o_vid_rvalid) begin
                vec++;
                if (n_rv >= 4) begin
                    err++;
                    $display("FAIL vid_extra_rvalid: got pulse at cycle %0d want none", k);
                end else if (k != n_rv + 4 || o_vid_rdata !== exp_d[n_rv]) begin
                    err++;
                    $display("FAIL vid_ret%0d: got %h at cycle %0d want %h at %0d",
                             n_rv, o_vid_rdata, k, exp_d[n_rv], n_rv + 4);
                end
                n_rv++;
            end
            if (k == 2 || k == 9) begin
                vec++;
                if (o_busy !== (k == 2)) begin
                    err++;
                    $display("FAIL busy_k%0d: got %b want %b", k, o_busy, (k == 2));
                end
            end
        end
        vec++;
        if (n_ce != 4 || n_rv != 4 || n_ack != 1) begin
            err++;
            $display("FAIL vid_counts: got ce %0d rv %0d ack %0d want 4 4 1",
                     n_ce, n_rv, n_ack);
        end
    endtask

    task automatic test_simultaneous();
        int         ret_k [5];
        logic       ret_c [5];
        logic [7:0] ret_d [5];
        logic [20:0] exp_ad;
        int n_ret;
        ret_k = '{4, 5, 6, 7, 8};
        ret_c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ret_d = '{8'hA5, 8'hA4, 8'hA7, 8'hA6, 8'h5A};
        n_ret = 0;
        do_reset();
        i_vid_req  = 1'b1;
        i_vid_addr = 21'h000100;
        i_cpu_req  = 1'b1;
        i_cpu_we   = 1'b0;
        i_cpu_addr = 21'h012345;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (o_mem_ce) begin
                vec++;
                exp_ad = (k <= 4) ? 21'h000100 + 21'(k - 1) : 21'h012345;
                if (k > 5 || o_mem_addr !== exp_ad || o_mem_we !== 1'b0) begin
                    err++;
                    $display("FAIL sim_issue_k%0d: got addr %h we %b want %h 0",
                             k, o_mem_addr, o_mem_we, exp_ad);
                end
            end
            if (o_vid_ack) i_vid_req = 1'b0;
            if (o_vid_rvalid || o_cpu_ack) begin
                vec++;
                if (n_ret >= 5) begin
                    err++;
                    $display("FAIL sim_extra_return: got return at cycle %0d want none", k);
                end else if (k != ret_k[n_ret] || o_cpu_ack !== ret_c[n_ret] ||
                             o_vid_rvalid !== !ret_c[n_ret] ||
                             (ret_c[n_ret] ? o_cpu_rdata : o_vid_rdata) !== ret_d[n_ret]) begin
                    err++;
                    $display("FAIL sim_ret%0d: got cyc %0d cpu %b vid %b data %h want cyc %0d cpu %b data %h",
                             n_ret, k, o_cpu_ack, o_vid_rvalid,
                             ret_c[n_ret] ? o_cpu_rdata : o_vid_rdata,
                             ret_k[n_ret], ret_c[n_ret], ret_d[n_ret]);
                end
                n_ret++;
            end
            if (o_cpu_ack) i_cpu_req = 1'b0;
        end
        vec++;
        if (n_ret != 5) begin
            err++;
            $display("FAIL sim_return_count: got %0d want 5", n_ret);
        end
    endtask

    task automatic test_fair_alternation();
        logic        exp_cpu, exp_vack, exp_cack, exp_rv;
        logic [20:0] exp_ad;
        logic [7:0]  exp_vd;
        int          j;
        do_reset();
        i_vid_req  = 1'b1;
        i_vid_addr = 21'h000200;
        i_cpu_req  = 1'b1;
        i_cpu_we   = 1'b0;
        i_cpu_addr = 21'h012345;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            exp_cpu  = (k % 5 == 0);
            exp_ad   = exp_cpu ? 21'h012345 : 21'h000200 + 21'((k - 1) % 5);
            exp_vack = (k % 5 == 1);
            exp_cack = (k >= 8 && k % 5 == 3);
            j        = k - 3;
            exp_rv   = (j >= 1 && j % 5 != 0);
            exp_vd   = 8'hA5 ^ 8'((j - 1) % 5);
            vec++;
            if (o_mem_ce !== 1'b1 || o_mem_addr !== exp_ad || o_mem_we !== 1'b0) begin
                err++;
                $display("FAIL alt_issue_k%0d: got ce %b addr %h want 1 %h",
                         k, o_mem_ce, o_mem_addr, exp_ad);
            end
            vec++;
            if (o_vid_ack !== exp_vack) begin
                err++;
                $display("FAIL alt_vack_k%0d: got %b want %b", k, o_vid_ack, exp_vack);
            end
            vec++;
            if (o_cpu_ack !== exp_cack || (exp_cack && o_cpu_rdata !== 8'h5A)) begin
                err++;
                $display("FAIL alt_cack_k%0d: got %b data %h want %b data 5a",
                         k, o_cpu_ack, o_cpu_rdata, exp_cack);
            end
            vec++;
            if (o_vid_rvalid !== exp_rv || (exp_rv && o_vid_rdata !== exp_vd)) begin
                err++;
                $display("FAIL alt_rv_k%0d: got %b data %h want %b data %h",
                         k, o_vid_rvalid, o_vid_rdata, exp_rv, exp_vd);
            end
        end
        i_vid_req = 1'b0;
        i_cpu_req = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        logic [69:0] outs;
        int          n_ce, k_ack;
        logic [7:0]  rd_s;
        i_vid_req  = 1'b1;
        i_vid_addr = 21'h000300;
        @(negedge clk);
        vec++;
        if (o_mem_ce !== 1'b1 || o_vid_ack !== 1'b1) begin
            err++;
            $display("FAIL rst_burst_start: got ce %b ack %b want 1 1", o_mem_ce, o_vid_ack);
        end
        i_vid_req = 1'b0;
        @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        outs = {o_cpu_ack, o_cpu_rdata, o_vid_ack, o_vid_rvalid, o_vid_rdata,
                o_mem_ce, o_mem_we, o_mem_addr, o_mem_wdata, o_busy};
        vec++;
        if (outs !== '0) begin
            err++;
            $display("FAIL rst_mid_outputs: got %h want 0", outs);
        end
        for (int k = 4; k <= 10; k++) begin
            @(negedge clk);
            vec++;
            if (o_vid_rvalid !== 1'b0 || o_cpu_ack !== 1'b0 || o_mem_ce !== 1'b0) begin
                err++;
                $display("FAIL rst_quiet_k%0d: got rv %b ack %b ce %b want 0 0 0",
                         k, o_vid_rvalid, o_cpu_ack, o_mem_ce);
            end
        end
        i_cpu_req  = 1'b1;
        i_cpu_we   = 1'b0;
        i_cpu_addr = 21'h012345;
        n_ce = 0; k_ack = -1; rd_s = 'x;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (o_mem_ce) n_ce++;
            if (o_cpu_ack) begin
                if (k_ack < 0) k_ack = k;
                rd_s = o_cpu_rdata;
                i_cpu_req = 1'b0;
            end
        end
        vec++;
        if (n_ce != 1 || k_ack != 4 || rd_s !== 8'h5A) begin
            err++;
            $display("FAIL rst_cpu_read: got ce %0d ack at %0d data %h want 1 4 5a",
                     n_ce, k_ack, rd_s);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_vid_burst_wrap();
        test_simultaneous();
        test_fair_alternation();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
